l2_response_queue: RTL and testbench
====================================

// Module: l2_response_queue
//
// PURPOSE
// - Elastic buffer directly downstream of the L2 update stage. Captures every
//   l2_response packet, holds it until the core-side interconnect accepts it,
//   and presents packets in arrival order.
// - The L2 pipeline cannot stall, so the queue raises an early almost-full
//   flag. The L2 request arbiter uses it to stop issuing new requests while
//   responses are still in flight.
//
// PARAMETERS
// - DEPTH          default 8   number of packet entries; power of 2, >= 4
// - INFLIGHT_SLACK default 4   entries reserved for requests already inside
//                              the L2 pipeline; must be < DEPTH
//
// PORTS
// clk                  in   1      clock
// reset                in   1      asynchronous, active-low reset
// l2_response_valid    in   1      packet from update stage valid this cycle
// l2_response          in   l2rsp_packet_t  response packet from update stage
// rspq_ready           in   1      interconnect accepts head packet this cycle
// rspq_valid           out  1      head packet valid
// rspq_packet          out  l2rsp_packet_t  head packet (registered)
// rspq_almost_full     out  1      to L2 arbiter: stop issuing new requests
// rspq_overflow        out  1      sticky error: a packet was dropped
// rspq_count           out  $clog2(DEPTH+1)  current occupancy
//
// BEHAVIOUR
// - Reset (reset low, async assert, sync deassert):
//   - rspq_valid = 0, rspq_almost_full = 0, rspq_overflow = 0, rspq_count = 0.
//   - rspq_packet is don't-care.
//   - Read/write pointers go to 0.
// - Storage: circular array of DEPTH entries.
//   - Write and read pointers are $clog2(DEPTH) bits and wrap naturally.
//   - Occupancy counter is $clog2(DEPTH+1) bits.
// - Push = l2_response_valid. Pop = rspq_valid && rspq_ready.
// - Latency: a push into an empty queue appears on rspq_valid/rspq_packet on
//   the next rising edge (1 cycle). There is no combinational input-to-output
//   path.
// - Output register holds the head entry.
//   - rspq_packet is stable while rspq_valid && !rspq_ready.
//   - Standard valid/ready rule: valid never deasserts without a pop.
// - Order: strict FIFO. Packets are never reordered or merged across cores.
// - Simultaneous push and pop:
//   - Count is unchanged. Allowed at any occupancy, including full.
//   - When full, the pop frees the slot the push uses; no drop occurs.
//   - When the count is 1, the new packet becomes head on the next cycle,
//     with no bubble.
// - Push while full without pop:
//   - The packet is discarded and storage is unchanged.
//   - rspq_overflow sets and stays 1 until reset.
//   - Simulation assertion fires.
// - Pop while empty cannot occur, because rspq_valid = 0.
// - rspq_almost_full is registered.
//   - Next value = (next_count >= DEPTH - INFLIGHT_SLACK).
//   - Deasserts the cycle after the count falls below the threshold.
// - rspq_count is the registered occupancy, including the head entry.
//
// TESTING
// 1. Reset low mid-traffic (count=5) -> next cycle valid=0, count=0,
//    almost_full=0, overflow=0.
// 2. Push A at cycle 0, empty queue, ready=1 -> rspq_valid=1 with A at
//    cycle 1, popped; valid=0 at cycle 2.
// 3. Push id=0..7 with ready=0 (DEPTH=8) -> count=8, almost_full=1 after
//    the 4th push. Then ready=1 -> ids 0..7 out in order, one per cycle.
// 4. Full queue, push + pop in the same cycle -> count stays 8,
//    overflow=0, new packet is delivered last.
// 5. Full queue, push with ready=0 -> overflow=1 (sticky), count=8, the
//    dropped packet never appears.
// 6. ready toggling 1/0 during a 20-packet stream with pointer wrap ->
//    rspq_packet stable while stalled; output sequence equals input
//    sequence.

Source files
------------

// File: rtl/l2_response_queue.sv
// In-order elastic buffer for L2 responses; 1-cycle push-to-head latency, registered head/flags.
// Backpressure: head held while rspq_ready=0; early almost-full throttles the arbiter, pushes while full are dropped.
package l2_response_queue_pkg;
   typedef struct packed {
      logic [1:0]  core;
      logic [7:0]  id;
      logic [31:0] data;
   } l2rsp_packet_t;
endpackage

module l2_response_queue
   import l2_response_queue_pkg::*;
#(
   parameter int DEPTH          = 8,
   parameter int INFLIGHT_SLACK = 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       l2_response_valid,
   input  l2rsp_packet_t              l2_response,
   input  logic                       rspq_ready,
   output logic                       rspq_valid,
   output l2rsp_packet_t              rspq_packet,
   output logic                       rspq_almost_full,
   output logic                       rspq_overflow,
   output logic [$clog2(DEPTH+1)-1:0] rspq_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);
   localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
   localparam logic [CW-1:0] AF_THRESH = CW'(DEPTH - INFLIGHT_SLACK);

   l2rsp_packet_t r_mem [DEPTH];
   l2rsp_packet_t r_packet;
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic          r_valid;
   logic          r_almost_full;
   logic          r_overflow;

   logic          w_push;
   logic          w_pop;
   logic          w_full;
   logic          w_wr_en;
   logic          w_drop;
   logic [CW-1:0] w_cnt_after_pop;
   logic [CW-1:0] w_cnt_next;
   logic [PW-1:0] w_rd_ptr_next;
   l2rsp_packet_t w_head_next;

   assign w_push          = l2_response_valid;
   assign w_pop           = r_valid && rspq_ready;
   assign w_full          = (r_count == FULL_CNT);
   // A pop in the same cycle frees the slot, so a full queue still accepts.
   assign w_wr_en         = w_push && (!w_full || w_pop);
   assign w_drop          = w_push && w_full && !w_pop;
   assign w_cnt_after_pop = r_count - CW'(w_pop);
   assign w_cnt_next      = w_cnt_after_pop + CW'(w_wr_en);
   assign w_rd_ptr_next   = r_rd_ptr + PW'(w_pop);

   // Bypass the array when the incoming packet becomes head, avoiding a bubble.
   assign w_head_next = (w_cnt_after_pop == '0) ? l2_response : r_mem[w_rd_ptr_next];

   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         r_mem[r_wr_ptr] <= l2_response;
      end
      r_packet <= w_head_next;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr      <= '0;
         r_rd_ptr      <= '0;
         r_count       <= '0;
         r_valid       <= 1'b0;
         r_almost_full <= 1'b0;
         r_overflow    <= 1'b0;
      end else begin
         if (w_wr_en) begin
            r_wr_ptr <= r_wr_ptr + PW'(1);
         end
         r_rd_ptr      <= w_rd_ptr_next;
         r_count       <= w_cnt_next;
         r_valid       <= (w_cnt_next != '0);
         r_almost_full <= (w_cnt_next >= AF_THRESH);
         if (w_drop) begin
            r_overflow <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         assert (!w_drop) else $warning("l2_response_queue: push while full, packet dropped");
      end
   end

   assign rspq_valid       = r_valid;
   assign rspq_packet      = r_packet;
   assign rspq_almost_full = r_almost_full;
   assign rspq_overflow    = r_overflow;
   assign rspq_count       = r_count;

endmodule

// File: tb/tb_l2_response_queue.sv
// Bench for l2_response_queue: constant-expectation vector table plus a queue model scoreboard.
module tb_l2_response_queue;
   import l2_response_queue_pkg::*;

   localparam int DEPTH = 8;
   localparam int SLACK = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          l2_response_valid;
   l2rsp_packet_t l2_response;
   logic          rspq_ready;
   logic          rspq_valid;
   l2rsp_packet_t rspq_packet;
   logic          rspq_almost_full;
   logic          rspq_overflow;
   logic [3:0]    rspq_count;

   l2_response_queue #(.DEPTH(DEPTH), .INFLIGHT_SLACK(SLACK)) dut (
      .clk               (clk),
      .reset             (reset),
      .l2_response_valid (l2_response_valid),
      .l2_response       (l2_response),
      .rspq_ready        (rspq_ready),
      .rspq_valid        (rspq_valid),
      .rspq_packet       (rspq_packet),
      .rspq_almost_full  (rspq_almost_full),
      .rspq_overflow     (rspq_overflow),
      .rspq_count        (rspq_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       push;
      logic       rdy;
      logic [7:0] id;
      int         exp_cnt;
      logic       exp_vld;
      logic       exp_af;
      logic       exp_ovf;
   } vec_t;

   vec_t          tbl[$];
   l2rsp_packet_t sb_q[$];
   logic          m_ovf;
   int            n_got;
   int            total;
   int            bad;

   function automatic l2rsp_packet_t mk(input logic [7:0] id);
      l2rsp_packet_t p;
      p.core = id[1:0];
      p.id   = id;
      p.data = {id, ~id, id ^ 8'h5a, 8'hc3};
      return p;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_model(input string tag);
      chk({tag, ".valid"}, 64'(rspq_valid), 64'(sb_q.size() != 0));
      chk({tag, ".count"}, 64'(rspq_count), 64'(sb_q.size()));
      chk({tag, ".af"}, 64'(rspq_almost_full), 64'(sb_q.size() >= DEPTH - SLACK));
      chk({tag, ".ovf"}, 64'(rspq_overflow), 64'(m_ovf));
      if (sb_q.size() != 0) begin
         chk({tag, ".head"}, 64'(rspq_packet), 64'(sb_q[0]));
      end
   endtask

   // Called between edges: drive inputs, advance the model, check after the next edge.
   task automatic cycle(input string tag, input logic p, input logic r, input logic [7:0] id);
      logic m_pop;
      logic m_acc;
      l2_response_valid = p;
      l2_response       = mk(id);
      rspq_ready        = r;
      m_pop = (sb_q.size() != 0) && r;
      m_acc = p && ((sb_q.size() < DEPTH) || m_pop);
      if (p && !m_acc) m_ovf = 1'b1;
      if (m_pop) begin
         void'(sb_q.pop_front());
         n_got++;
      end
      if (m_acc) sb_q.push_back(mk(id));
      @(posedge clk);
      @(negedge clk);
      check_model(tag);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      n_got = 0;
      m_ovf = 1'b0;
      reset = 1'b0;
      l2_response_valid = 1'b0;
      l2_response       = mk(8'h00);
      rspq_ready        = 1'b0;

      // single push/pop, then fill 0..7, push+pop at full, drop at full, drain
      tbl.push_back('{1'b1, 1'b1, 8'hA0, 1, 1'b1, 1'b0, 1'b0});
      tbl.push_back('{1'b0, 1'b1, 8'h00, 0, 1'b0, 1'b0, 1'b0});
      for (int i = 0; i < 8; i++)
         tbl.push_back('{1'b1, 1'b0, 8'(i), i + 1, 1'b1, (i >= 3), 1'b0});
      tbl.push_back('{1'b1, 1'b1, 8'h08, 8, 1'b1, 1'b1, 1'b0});
      tbl.push_back('{1'b1, 1'b0, 8'h09, 8, 1'b1, 1'b1, 1'b1});
      for (int i = 7; i >= 0; i--)
         tbl.push_back('{1'b0, 1'b1, 8'h00, i, (i != 0), (i >= 4), 1'b1});

      repeat (2) @(negedge clk);
      chk("rst.valid", 64'(rspq_valid), 64'd0);
      chk("rst.count", 64'(rspq_count), 64'd0);
      chk("rst.af", 64'(rspq_almost_full), 64'd0);
      chk("rst.ovf", 64'(rspq_overflow), 64'd0);
      reset = 1'b1;
      @(negedge clk);

      foreach (tbl[i]) begin
         cycle($sformatf("vec%0d", i), tbl[i].push, tbl[i].rdy, tbl[i].id);
         chk($sformatf("vec%0d.cnt", i), 64'(rspq_count), 64'(tbl[i].exp_cnt));
         chk($sformatf("vec%0d.vld", i), 64'(rspq_valid), 64'(tbl[i].exp_vld));
         chk($sformatf("vec%0d.af", i), 64'(rspq_almost_full), 64'(tbl[i].exp_af));
         chk($sformatf("vec%0d.ovf", i), 64'(rspq_overflow), 64'(tbl[i].exp_ovf));
      end
      chk("drain.popped", 64'(n_got), 64'd10);

      // asynchronous reset in the middle of traffic at count 5
      for (int i = 0; i < 5; i++) cycle("fill5", 1'b1, 1'b0, 8'(8'h40 + i));
      chk("fill5.count", 64'(rspq_count), 64'd5);
      #2;
      reset = 1'b0;
      #1;
      chk("arst.valid", 64'(rspq_valid), 64'd0);
      chk("arst.count", 64'(rspq_count), 64'd0);
      chk("arst.af", 64'(rspq_almost_full), 64'd0);
      chk("arst.ovf", 64'(rspq_overflow), 64'd0);
      sb_q.delete();
      m_ovf = 1'b0;
      l2_response_valid = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // 20-packet stream with ready toggling, wraps the pointers twice
      begin
         int sent;
         int cyc;
         sent  = 0;
         cyc   = 0;
         n_got = 0;
         while ((n_got < 20) && (cyc < 300)) begin
            logic p;
            logic r;
            p = (sent < 20) && (sb_q.size() < 6) && ($urandom_range(0, 3) != 0);
            r = cyc[0] ^ ($urandom_range(0, 4) == 0);
            cycle("stream", p, r, 8'(8'h80 + sent));
            if (p) sent++;
            cyc++;
         end
         chk("stream.all", 64'(n_got), 64'd20);
      end
      cycle("idle", 1'b0, 1'b1, 8'h00);
      chk("idle.valid", 64'(rspq_valid), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
